// File: rtl/lc4_perf_pkg.sv
// ============================================================================
// Module      : lc4_perf_pkg
// Description : Shared encodings for the LC4 retirement/stall monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lc4_perf_pkg;

    // Monitor FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    // test_stall codes driven by the processor
    localparam logic [1:0] STALL_NONE   = 2'd0;
    localparam logic [1:0] STALL_CACHE  = 2'd1;
    localparam logic [1:0] STALL_BRANCH = 2'd2;
    localparam logic [1:0] STALL_LOAD   = 2'd3;

    // Counter indices as seen on rd_sel
    localparam logic [2:0] SEL_CYCLES     = 3'd0;
    localparam logic [2:0] SEL_RETIRED    = 3'd1;
    localparam logic [2:0] SEL_CACHE      = 3'd2;
    localparam logic [2:0] SEL_BRANCH     = 3'd3;
    localparam logic [2:0] SEL_LOAD       = 3'd4;
    localparam logic [2:0] SEL_REGFILE_WE = 3'd5;
    localparam logic [2:0] SEL_NZP_WE     = 3'd6;
    localparam logic [2:0] SEL_DMEM_WE    = 3'd7;

    localparam int NUM_CNT = 8;

    localparam logic [19:0] LC4_HALT_INSN = 20'h88000;

    // Architectural write enables of the retiring instruction
    typedef struct packed {
        logic regfile;
        logic nzp;
        logic dmem;
    } wr_en_t;

endpackage : lc4_perf_pkg

`default_nettype wire

// File: rtl/lc4_sat_counter.sv
// ============================================================================
// Module      : lc4_sat_counter
// Description : Event counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lc4_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + C_ONE;
        end
    end

    assign q = r_q;

endmodule : lc4_sat_counter

`default_nettype wire

// File: rtl/lc4_perf_monitor.sv
// ============================================================================
// Module      : lc4_perf_monitor
// Description : Cycle/retire/stall/write-event monitor with HALT detection
//               and a registered counter readout port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lc4_perf_monitor
    import lc4_perf_pkg::*;
#(
    parameter int              INSN      = 19,
    parameter int              CNT_W     = 32,
    parameter logic [INSN:0]   HALT_INSN = LC4_HALT_INSN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gwe,
    input  logic             clear,
    input  logic [1:0]       test_stall,
    input  logic [INSN:0]    test_cur_insn,
    input  logic             test_regfile_we,
    input  logic             test_nzp_we,
    input  logic             test_dmem_we,
    input  logic [2:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             running,
    output logic             halted
);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_running;
    logic             r_halted;
    logic [CNT_W-1:0] r_rd_data;

    logic             w_sample;
    logic             w_retire;
    logic             w_is_halt;
    wr_en_t           w_wr_en;
    logic [NUM_CNT-1:0] w_inc;
    logic [CNT_W-1:0] w_cnt [NUM_CNT];

    // A clear in the same cycle as a sample drops the sample entirely.
    assign w_sample  = gwe && !clear && (r_state != ST_HALTED);
    assign w_retire  = w_sample && (test_stall == STALL_NONE);
    assign w_is_halt = w_retire && (test_cur_insn == HALT_INSN);

    assign w_wr_en.regfile = test_regfile_we;
    assign w_wr_en.nzp     = test_nzp_we;
    assign w_wr_en.dmem    = test_dmem_we;

    // Write enables only count on retire samples; stall slots carry bubbles.
    always_comb begin
        w_inc                 = '0;
        w_inc[SEL_CYCLES]     = w_sample;
        w_inc[SEL_RETIRED]    = w_retire;
        w_inc[SEL_CACHE]      = w_sample && (test_stall == STALL_CACHE);
        w_inc[SEL_BRANCH]     = w_sample && (test_stall == STALL_BRANCH);
        w_inc[SEL_LOAD]       = w_sample && (test_stall == STALL_LOAD);
        w_inc[SEL_REGFILE_WE] = w_retire && w_wr_en.regfile;
        w_inc[SEL_NZP_WE]     = w_retire && w_wr_en.nzp;
        w_inc[SEL_DMEM_WE]    = w_retire && w_wr_en.dmem;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else if (w_is_halt) begin
            w_state_nxt = ST_HALTED;
        end else if (w_sample) begin
            w_state_nxt = ST_RUN;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            lc4_sat_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk (clk),
                .rst (rst),
                .inc (w_inc[gi]),
                .clr (clear),
                .q   (w_cnt[gi])
            );
        end
    endgenerate

    // Readout samples the counters before this edge's update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
            r_halted  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == ST_RUN);
            r_halted  <= (w_state_nxt == ST_HALTED);
            r_rd_data <= w_cnt[rd_sel];
        end
    end

    assign rd_data = r_rd_data;
    assign running = r_running;
    assign halted  = r_halted;

endmodule : lc4_perf_monitor

`default_nettype wire

// File: tb/tb_lc4_perf_monitor.sv
// ============================================================================
// Module      : tb_lc4_perf_monitor
// Description : Scoreboard bench for lc4_perf_monitor (32-bit and 4-bit builds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lc4_perf_monitor;

    localparam logic [19:0] C_HALT = 20'h88000;
    localparam int          C_IDLE = 0;
    localparam int          C_RUN  = 1;
    localparam int          C_HLT  = 2;

    logic        clk;
    logic        rst;
    logic        gwe;
    logic        clear;
    logic [1:0]  test_stall;
    logic [19:0] test_cur_insn;
    logic        test_regfile_we;
    logic        test_nzp_we;
    logic        test_dmem_we;
    logic [2:0]  rd_sel;
    logic [31:0] rd_data;
    logic        running;
    logic        halted;
    logic [3:0]  rd_data_s;
    logic        running_s;
    logic        halted_s;

    lc4_perf_monitor #(.INSN(19), .CNT_W(32), .HALT_INSN(C_HALT)) u_dut (
        .clk(clk), .rst(rst), .gwe(gwe), .clear(clear),
        .test_stall(test_stall), .test_cur_insn(test_cur_insn),
        .test_regfile_we(test_regfile_we), .test_nzp_we(test_nzp_we),
        .test_dmem_we(test_dmem_we), .rd_sel(rd_sel),
        .rd_data(rd_data), .running(running), .halted(halted)
    );

    lc4_perf_monitor #(.INSN(19), .CNT_W(4), .HALT_INSN(C_HALT)) u_dut_s (
        .clk(clk), .rst(rst), .gwe(gwe), .clear(clear),
        .test_stall(test_stall), .test_cur_insn(test_cur_insn),
        .test_regfile_we(test_regfile_we), .test_nzp_we(test_nzp_we),
        .test_dmem_we(test_dmem_we), .rd_sel(rd_sel),
        .rd_data(rd_data_s), .running(running_s), .halted(halted_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        logic [31:0] big;
        logic [3:0]  sm;
    } sb_t;

    sb_t         exp_q[$];
    sb_t         obs_q[$];
    logic [31:0] m_big [8];
    logic [3:0]  m_sm  [8];
    int          m_state;
    int          n_checks;
    int          n_fail;

    function automatic void bump(input int i);
        if (m_big[i] != 32'hFFFF_FFFF) m_big[i] = m_big[i] + 32'd1;
        if (m_sm[i] != 4'hF)           m_sm[i]  = m_sm[i] + 4'd1;
    endfunction

    // Drives one clock: expected readout is pushed before the edge, observed after.
    task automatic step(input logic r, input logic c, input logic g, input logic [1:0] st,
                        input logic [19:0] insn, input logic rf, input logic nz,
                        input logic dm, input logic [2:0] sel);
        sb_t e;
        sb_t o;
        rst = r; clear = c; gwe = g; test_stall = st; test_cur_insn = insn;
        test_regfile_we = rf; test_nzp_we = nz; test_dmem_we = dm; rd_sel = sel;
        e.sel = int'(sel);
        e.big = r ? 32'd0 : m_big[sel];
        e.sm  = r ? 4'd0  : m_sm[sel];
        exp_q.push_back(e);
        if (r || c) begin
            for (int i = 0; i < 8; i++) begin
                m_big[i] = '0;
                m_sm[i]  = '0;
            end
            m_state = C_IDLE;
        end else if (g && m_state != C_HLT) begin
            bump(0);
            if (st == 2'd0) begin
                bump(1);
                if (rf) bump(5);
                if (nz) bump(6);
                if (dm) bump(7);
                m_state = (insn == C_HALT) ? C_HLT : C_RUN;
            end else begin
                bump(int'(st) + 1);
                m_state = C_RUN;
            end
        end
        @(posedge clk);
        #1;
        o.sel = int'(sel);
        o.big = rd_data;
        o.sm  = rd_data_s;
        obs_q.push_back(o);
    endtask

    task automatic retire(input int n, input logic rf, input logic nz, input logic dm);
        for (int i = 0; i < n; i++) step(0, 0, 1, 2'd0, 20'h01234 + 20'(i), rf, nz, dm, 3'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 2'd0, 20'h0, 0, 0, 0, 3'd0);
    endtask

    task automatic read_all();
        for (int i = 0; i < 8; i++) step(0, 0, 0, 2'd0, 20'h0, 0, 0, 0, 3'(i));
        step(0, 0, 0, 2'd0, 20'h0, 0, 0, 0, 3'd0);
    endtask

    task automatic test_reset();
        step(1, 0, 0, 2'd0, 20'h0, 0, 0, 0, 3'd0);
        step(1, 0, 1, 2'd0, 20'h0, 1, 1, 1, 3'd1);
        read_all();
        n_checks++;
        if (running !== 1'b0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: running=%b halted=%b, required 0/0", running, halted);
        end
        while (exp_q.size() > 0) begin
            sb_t e;
            sb_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.big !== e.big || o.sm !== e.sm) begin
                n_fail++;
                $display("FAIL reset rd_data sel=%0d: got %h/%h, required %h/%h", e.sel, o.big, o.sm, e.big, e.sm);
            end
        end
    endtask

    task automatic test_retire_stream();
        idle(2);
        n_checks++;
        if (running !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_gwe running: got %b, required 0", running);
        end
        retire(10, 1, 0, 0);
        n_checks++;
        if (running !== 1'b1 || running_s !== 1'b1) begin
            n_fail++;
            $display("FAIL retire_stream running: got %b/%b, required 1", running, running_s);
        end
        read_all();
        while (exp_q.size() > 0) begin
            sb_t e;
            sb_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.big !== e.big || o.sm !== e.sm) begin
                n_fail++;
                $display("FAIL retire_stream rd_data sel=%0d: got %h/%h, required %h/%h", e.sel, o.big, o.sm, e.big, e.sm);
            end
        end
    endtask

    task automatic test_stall_mix();
        step(0, 1, 0, 2'd0, 20'h0, 0, 0, 0, 3'd0);
        n_checks++;
        if (running !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_mix clear_state running: got %b, required 0", running);
        end
        for (int i = 0; i < 3; i++) begin step(0, 0, 1, 2'd0, 20'h00100, 0, 1, 0, 3'd1); idle(3); end
        for (int i = 0; i < 2; i++) begin step(0, 0, 1, 2'd1, 20'h00200, 1, 1, 1, 3'd2); idle(3); end
        for (int i = 0; i < 4; i++) begin step(0, 0, 1, 2'd2, 20'h00300, 1, 0, 1, 3'd3); idle(3); end
        step(0, 0, 1, 2'd3, 20'h00400, 1, 1, 1, 3'd4);
        idle(3);
        read_all();
        while (exp_q.size() > 0) begin
            sb_t e;
            sb_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.big !== e.big || o.sm !== e.sm) begin
                n_fail++;
                $display("FAIL stall_mix rd_data sel=%0d: got %h/%h, required %h/%h", e.sel, o.big, o.sm, e.big, e.sm);
            end
        end
    endtask

    task automatic test_halt();
        // HALT encoding in a stall slot must not terminate the run.
        step(0, 0, 1, 2'd1, C_HALT, 0, 0, 1, 3'd7);
        n_checks++;
        if (halted !== 1'b0 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_in_stall: halted=%b running=%b, required 0/1", halted, running);
        end
        step(0, 0, 1, 2'd0, C_HALT, 0, 0, 1, 3'd7);
        retire(5, 1, 1, 1);
        n_checks++;
        if (halted !== 1'b1 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_flags: halted=%b running=%b, required 1/0", halted, running);
        end
        read_all();
        while (exp_q.size() > 0) begin
            sb_t e;
            sb_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.big !== e.big || o.sm !== e.sm) begin
                n_fail++;
                $display("FAIL halt rd_data sel=%0d: got %h/%h, required %h/%h", e.sel, o.big, o.sm, e.big, e.sm);
            end
        end
    endtask

    task automatic test_saturation();
        step(1, 0, 0, 2'd0, 20'h0, 0, 0, 0, 3'd0);
        retire(20, 1, 0, 1);
        read_all();
        step(0, 1, 0, 2'd0, 20'h0, 0, 0, 0, 3'd1);
        n_checks++;
        if (running !== 1'b0 || halted !== 1'b0 || running_s !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_clear_state: running=%b halted=%b, required 0/0", running, halted);
        end
        read_all();
        retire(1, 0, 0, 0);
        n_checks++;
        if (running !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_rearm running: got %b, required 1", running);
        end
        while (exp_q.size() > 0) begin
            sb_t e;
            sb_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.big !== e.big || o.sm !== e.sm) begin
                n_fail++;
                $display("FAIL saturation rd_data sel=%0d: got %h/%h, required %h/%h", e.sel, o.big, o.sm, e.big, e.sm);
            end
        end
    endtask

    task automatic test_clear_collision();
        retire(3, 1, 1, 0);
        step(0, 1, 1, 2'd0, 20'h00555, 1, 1, 1, 3'd0);
        n_checks++;
        if (running !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_collision running: got %b, required 0", running);
        end
        read_all();
        retire(4, 0, 1, 1);
        step(1, 0, 1, 2'd0, 20'h00666, 1, 1, 1, 3'd1);
        n_checks++;
        if (running !== 1'b0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_run flags: running=%b halted=%b, required 0/0", running, halted);
        end
        read_all();
        while (exp_q.size() > 0) begin
            sb_t e;
            sb_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.big !== e.big || o.sm !== e.sm) begin
                n_fail++;
                $display("FAIL clear_collision rd_data sel=%0d: got %h/%h, required %h/%h", e.sel, o.big, o.sm, e.big, e.sm);
            end
        end
    endtask

    task automatic test_back_to_back();
        retire(6, 0, 0, 0);
        step(0, 0, 0, 2'd0, 20'h0, 0, 0, 0, 3'd0);
        step(0, 0, 0, 2'd0, 20'h0, 0, 0, 0, 3'd1);
        // Reads taken on sampling cycles must return the pre-increment value.
        for (int i = 0; i < 4; i++) step(0, 0, 1, 2'(i % 4), 20'h00777, 1, 0, 0, 3'(i % 2));
        for (int i = 0; i < 6; i++) step(0, 0, 1, 2'(i % 4), 20'h00888, 0, 1, 1, 3'(i + 2));
        read_all();
        while (exp_q.size() > 0) begin
            sb_t e;
            sb_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.big !== e.big || o.sm !== e.sm) begin
                n_fail++;
                $display("FAIL back_to_back rd_data sel=%0d: got %h/%h, required %h/%h", e.sel, o.big, o.sm, e.big, e.sm);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_state  = C_IDLE;
        for (int i = 0; i < 8; i++) begin
            m_big[i] = '0;
            m_sm[i]  = '0;
        end
        rst = 1'b1; clear = 1'b0; gwe = 1'b0; test_stall = 2'd0; test_cur_insn = 20'h0;
        test_regfile_we = 1'b0; test_nzp_we = 1'b0; test_dmem_we = 1'b0; rd_sel = 3'd0;
        test_reset();
        test_retire_stream();
        test_stall_mix();
        test_halt();
        test_saturation();
        test_clear_collision();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_lc4_perf_monitor

`default_nettype wire
